fetch_icache: RTL and testbench

- Instruction-fetch stage that feeds the IF/ID pipeline register. It produces PCF, PC_plus_4F and InstrF.
- Holds the program counter and a direct-mapped instruction cache with one word per line.
- On a miss, a refill FSM fetches the word from backing memory over a req/ack handshake and raises a stall to the hazard unit.

---
 rtl/fetch_icache.sv | 132 +++++++++++++
 tb/tb_fetch_icache.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_icache.sv
// fetch_icache: instruction-fetch stage with a program counter and a
// direct-mapped, one-word-per-line instruction cache. A miss starts a refill
// over a req/ack handshake and holds CacheStall high until the line is installed.
// Optional perf counters: define ICACHE_PERF_EN to build hit_count/miss_count;
// otherwise both ports are tied to zero.
module fetch_icache #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    SETS       = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  EN,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic [DATA_WIDTH-1:0] PCF,
   output logic [DATA_WIDTH-1:0] PC_plus_4F,
   output logic [DATA_WIDTH-1:0] InstrF,
   output logic                  CacheStall,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = DATA_WIDTH - 2 - INDEX_W;

   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   pc;
   logic [SETS-1:0]         valid;
   logic [TAG_W-1:0]        tag_mem  [SETS];
   logic [DATA_WIDTH-1:0]   data_mem [SETS];

   logic [INDEX_W-1:0]      index;
   logic [TAG_W-1:0]        tag;
   logic [INDEX_W-1:0]      fill_index;
   logic                    hit;
   logic [DATA_WIDTH-1:0]   redirect_pc;

   // Lookup is purely combinational on the current PC.
   assign index       = pc[INDEX_W+1:2];
   assign tag         = pc[DATA_WIDTH-1:INDEX_W+2];
   assign fill_index  = mem_addr[INDEX_W+1:2];
   assign hit         = valid[index] && (tag_mem[index] == tag);
   assign redirect_pc = PCTargetE & WORD_MASK;

   assign PCF        = pc;
   assign PC_plus_4F = pc + DATA_WIDTH'(4);
   assign InstrF     = (state == IDLE && hit) ? data_mem[index] : NOP_INSTR;
   assign CacheStall = (state == IDLE && !hit) || (state == REFILL);

   // Program counter: advances only when the hazard unit allows it and no miss is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (EN && !CacheStall) begin
         pc <= PCSrcE ? redirect_pc : PC_plus_4F;
      end
   end

   // Refill FSM: owns the handshake outputs and the valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         valid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!hit) begin
                  state    <= REFILL;
                  mem_req  <= 1'b1;
                  mem_addr <= pc & WORD_MASK;
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  valid[fill_index] <= 1'b1;
                  mem_req           <= 1'b0;
                  state             <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage: written once per completed refill.
   always_ff @(posedge clk) begin
      // NOTE: tag/data arrays have no reset; the valid bits alone make stale contents unreachable.
      if (state == REFILL && mem_ack) begin
         data_mem[fill_index] <= mem_rdata;
         tag_mem[fill_index]  <= mem_addr[DATA_WIDTH-1:INDEX_W+2];
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // Perf counters: hits that deliver an instruction, and miss starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (state == IDLE && hit && EN) hit_q  <= hit_q + 32'd1;
         if (state == IDLE && !hit)      miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fetch_icache.sv
// Directed bench for fetch_icache: cold miss, sequential warm fetch, conflict
// miss, redirects (hit and in-flight miss), reset during refill, EN stall and
// PC wrap. Backing memory words come from mem_word().
module tb_fetch_icache;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        EN = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic [31:0] PCF, PC_plus_4F, InstrF, mem_addr, hit_count, miss_count;
   logic        CacheStall, mem_req;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;

   fetch_icache #(.DATA_WIDTH(32), .SETS(16), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .EN         (EN),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .PCF        (PCF),
      .PC_plus_4F (PC_plus_4F),
      .InstrF     (InstrF),
      .CacheStall (CacheStall),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a refill request, holds ack off for `delay` cycles, then acks.
   task automatic refill(input logic [31:0] addr, input int delay);
      int          n;
      logic [31:0] pc0;
      n   = 0;
      pc0 = PCF;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      check("req_seen", 32'(mem_req), 32'd1);
      check("req_addr", mem_addr, addr);
      repeat (delay) begin
         tick();
         check("req_hold", 32'(mem_req), 32'd1);
         check("req_addr_hold", mem_addr, addr);
         check("stall_hold", 32'(CacheStall), 32'd1);
         check("pc_hold", PCF, pc0);
      end
      mem_rdata = mem_word(addr);
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check("req_drop", 32'(mem_req), 32'd0);
      check("stall_end", 32'(CacheStall), 32'd0);
      check("fill_instr", InstrF, mem_word(addr));
      check("pc_after_fill", PCF, pc0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hc0, mc0;

      // 1. reset and cold miss at 0
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", PCF, 32'h0);
      check("rst_pc4", PC_plus_4F, 32'h4);
      check("rst_stall", 32'(CacheStall), 32'd1);
      check("rst_instr", InstrF, 32'h13);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_hits", hit_count, 32'd0);
      check("rst_misses", miss_count, 32'd0);
      #2 rst_n = 1'b1;
      EN = 1'b1;
      refill(32'h0, 2);
      check("t1_instr", InstrF, 32'h0050_0093);
      tick();
      check("t1_pc", PCF, 32'h4);

      // 2. warm 0x04..0x3C, loop back, then a full-hit second pass
      for (int a = 4; a <= 32'h3C; a += 4) begin
         check("warm_pc", PCF, 32'(a));
         check("warm_miss", 32'(CacheStall), 32'd1);
         refill(32'(a), 1);
         if (a == 32'h3C) begin
            PCSrcE    = 1'b1;
            PCTargetE = 32'h0;
         end
         tick();
      end
      hc0 = hit_count;
      for (int a = 0; a <= 32'h3C; a += 4) begin
         PCSrcE = 1'b0;
         check("pass2_pc", PCF, 32'(a));
         check("pass2_stall", 32'(CacheStall), 32'd0);
         check("pass2_instr", InstrF, mem_word(32'(a)));
         check("pass2_req", 32'(mem_req), 32'd0);
         tick();
      end
      check("pass2_end_pc", PCF, 32'h40);
`ifdef ICACHE_PERF_EN
      check("pass2_hits", hit_count - hc0, 32'd16);
`else
      check("pass2_hits", hit_count, 32'd0);
`endif

      // 3. conflict miss between 0x04 and 0x44 (both index 1)
      refill(32'h40, 1);
      PCSrcE    = 1'b1;
      PCTargetE = 32'h4;
      tick();
      check("t3_pc4", PCF, 32'h4);
      check("t3_hit4", 32'(CacheStall), 32'd0);
      check("t3_instr4", InstrF, mem_word(32'h4));
      mc0 = miss_count;
      PCTargetE = 32'h44;
      tick();
      check("t3_pc44", PCF, 32'h44);
      check("t3_miss44", 32'(CacheStall), 32'd1);
      refill(32'h44, 2);
      PCTargetE = 32'h4;
      tick();
      check("t3_ret_pc", PCF, 32'h4);
      check("t3_ret_miss", 32'(CacheStall), 32'd1);
      refill(32'h4, 1);
`ifdef ICACHE_PERF_EN
      check("t3_misses", miss_count - mc0, 32'd2);
`else
      check("t3_misses", miss_count, 32'd0);
`endif

      // 4. redirect on a hit, then redirect held across an in-flight miss
      PCTargetE = 32'h103;
      tick();
      check("t4_pc", PCF, 32'h100);
      PCSrcE = 1'b0;
      refill(32'h100, 1);
      tick();
      check("t4_pc104", PCF, 32'h104);
      PCSrcE    = 1'b1;
      PCTargetE = 32'h103;
      refill(32'h104, 3);
      tick();
      check("t4_pc_after", PCF, 32'h100);
      check("t4_hit100", 32'(CacheStall), 32'd0);
      PCSrcE = 1'b0;

      // 5. reset asserted mid-refill
      tick();
      check("t5_pc104", PCF, 32'h104);
      tick();
      check("t5_miss108", 32'(CacheStall), 32'd1);
      tick();
      check("t5_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_req_async", 32'(mem_req), 32'd0);
      check("t5_pc_async", PCF, 32'h0);
      check("t5_stall_async", 32'(CacheStall), 32'd1);
      check("t5_misses_async", miss_count, 32'd0);
      tick();
      rst_n = 1'b1;
      check("t5_pc_rel", PCF, 32'h0);
      refill(32'h0, 1);
      tick();
      check("t5_pc4", PCF, 32'h4);
      check("t5_inval4", 32'(CacheStall), 32'd1);
      refill(32'h4, 1);

      // 6. EN low on a hit, stray ack, and PC wrap
      PCSrcE    = 1'b1;
      PCTargetE = 32'h20;
      tick();
      check("t6_pc20", PCF, 32'h20);
      PCSrcE = 1'b0;
      refill(32'h20, 1);
      EN  = 1'b0;
      hc0 = hit_count;
      repeat (4) begin
         tick();
         check("t6_pc_hold", PCF, 32'h20);
         check("t6_instr_hold", InstrF, mem_word(32'h20));
         check("t6_stall", 32'(CacheStall), 32'd0);
      end
      mem_rdata = 32'hDEAD_BEEF;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check("t6_ack_ignored_req", 32'(mem_req), 32'd0);
      check("t6_ack_ignored_instr", InstrF, mem_word(32'h20));
      tick();
      check("t6_ack_ignored_stall", 32'(CacheStall), 32'd0);
`ifdef ICACHE_PERF_EN
      check("t6_hits_frozen", hit_count - hc0, 32'd0);
`else
      check("t6_hits_frozen", hit_count, 32'd0);
`endif
      EN        = 1'b1;
      PCSrcE    = 1'b1;
      PCTargetE = 32'hFFFF_FFFC;
      tick();
      check("wrap_pc", PCF, 32'hFFFF_FFFC);
      check("wrap_pc4", PC_plus_4F, 32'h0);
      PCSrcE = 1'b0;
      refill(32'hFFFF_FFFC, 1);
      tick();
      check("wrap_next", PCF, 32'h0);
      check("wrap_hit0", 32'(CacheStall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
